// File: rtl/gclk_stability_monitor.sv
// Multi-channel registered equivalent of the $steady/$changed/$rising/$falling_gclk
// sampled-value functions, with a minimum-stable-time rule and violation accounting.
module gclk_stability_monitor #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int MIN_STABLE = 3,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] sig_i,
    input  logic [CHANNELS-1:0]       en_i,
    input  logic                      clr_i,
    output logic [CHANNELS-1:0]       steady_o,
    output logic [CHANNELS-1:0]       changed_o,
    output logic [CHANNELS-1:0]       rose_o,
    output logic [CHANNELS-1:0]       fell_o,
    output logic [CHANNELS-1:0]       viol_o,
    output logic [CHANNELS-1:0]       err_o,
    output logic [CNT_W-1:0]          viol_cnt_o
);

    localparam int RUN_W = (MIN_STABLE > 0) ? $clog2(MIN_STABLE + 1) : 1;
    localparam int PC_W  = $clog2(CHANNELS + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_STABLE);
    localparam bit CHECK_EN = (MIN_STABLE > 0);

    // Saturating run-length increment; run never exceeds RUN_MAX.
    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] r);
        if (r == RUN_MAX)
            return RUN_MAX;
        return r + 1'b1;
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [CHANNELS-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int k = 0; k < CHANNELS; k++)
            n = n + PC_W'(v[k]);
        return n;
    endfunction

    // Counter add that clamps at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [PC_W-1:0]  inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        if (sum[SUM_W-1:CNT_W] != '0)
            return {CNT_W{1'b1}};
        return sum[CNT_W-1:0];
    endfunction

    logic [WIDTH-1:0]    prev_p1 [CHANNELS];
    logic [RUN_W-1:0]    run_p1  [CHANNELS];
    logic [CHANNELS-1:0] hv_p1;

    logic [WIDTH-1:0]    prev_p0 [CHANNELS];
    logic [RUN_W-1:0]    run_p0  [CHANNELS];
    logic [CHANNELS-1:0] hv_p0;
    logic [CHANNELS-1:0] steady_p0;
    logic [CHANNELS-1:0] changed_p0;
    logic [CHANNELS-1:0] rose_p0;
    logic [CHANNELS-1:0] fell_p0;
    logic [CHANNELS-1:0] viol_p0;
    logic [WIDTH-1:0]    cur;
    logic                diff;

    // Stage p0: compare each channel's sample against its history
    always_comb begin
        prev_p0    = prev_p1;
        run_p0     = run_p1;
        hv_p0      = hv_p1;
        steady_p0  = '0;
        changed_p0 = '0;
        rose_p0    = '0;
        fell_p0    = '0;
        viol_p0    = '0;
        cur        = '0;
        diff       = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            cur  = sig_i[i*WIDTH +: WIDTH];
            diff = (cur != prev_p1[i]);
            if (en_i[i]) begin
                prev_p0[i] = cur;
                hv_p0[i]   = 1'b1;
                if (!hv_p1[i]) begin
                    // Priming: no history yet, so the first change afterwards is legal.
                    run_p0[i] = RUN_MAX;
                end else begin
                    steady_p0[i]  = ~diff;
                    changed_p0[i] = diff;
                    rose_p0[i]    = ~prev_p1[i][0] & cur[0];
                    fell_p0[i]    = prev_p1[i][0] & ~cur[0];
                    if (diff) begin
                        viol_p0[i] = CHECK_EN && (run_p1[i] != RUN_MAX);
                        run_p0[i]  = '0;
                    end else begin
                        run_p0[i] = run_inc(run_p1[i]);
                    end
                end
            end else begin
                hv_p0[i]  = 1'b0;
                run_p0[i] = RUN_MAX;
            end
        end
    end

    // Stage p1: registered flags, history and violation accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hv_p1      <= '0;
            steady_o   <= '0;
            changed_o  <= '0;
            rose_o     <= '0;
            fell_o     <= '0;
            viol_o     <= '0;
            err_o      <= '0;
            viol_cnt_o <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                prev_p1[i] <= '0;
                run_p1[i]  <= RUN_MAX;
            end
        end else begin
            hv_p1     <= hv_p0;
            steady_o  <= steady_p0;
            changed_o <= changed_p0;
            rose_o    <= rose_p0;
            fell_o    <= fell_p0;
            viol_o    <= viol_p0;
            // A violation coinciding with clear survives the clear.
            err_o      <= (clr_i ? '0 : err_o) | viol_p0;
            viol_cnt_o <= sat_add(clr_i ? '0 : viol_cnt_o, popcount(viol_p0));
            for (int i = 0; i < CHANNELS; i++) begin
                prev_p1[i] <= prev_p0[i];
                run_p1[i]  <= run_p0[i];
            end
        end
    end

endmodule

// File: tb/tb_gclk_stability_monitor.sv
// Scoreboard bench for gclk_stability_monitor: directed scenarios then random traffic,
// checked against a cycle-count reference model.
module tb_gclk_stability_monitor;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int MS = 3;
    localparam int CW = 2;
    localparam int BIG = 1000;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk;
    logic            rst;
    logic [CH*W-1:0] sig_i;
    logic [CH-1:0]   en_i;
    logic            clr_i;
    logic [CH-1:0]   steady_o, changed_o, rose_o, fell_o, viol_o, err_o;
    logic [CW-1:0]   viol_cnt_o;

    gclk_stability_monitor #(
        .WIDTH(W), .CHANNELS(CH), .MIN_STABLE(MS), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .sig_i(sig_i), .en_i(en_i), .clr_i(clr_i),
        .steady_o(steady_o), .changed_o(changed_o), .rose_o(rose_o),
        .fell_o(fell_o), .viol_o(viol_o), .err_o(err_o), .viol_cnt_o(viol_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0] st, chg, ro, fe, vi, er;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: last sample, history flag, cycles since last change.
    logic [W-1:0]  cur    [CH];
    logic [W-1:0]  m_prev [CH];
    bit            m_hv   [CH];
    int            m_since[CH];
    logic [CH-1:0] m_err;
    int            m_cnt;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_prev[i]  = '0;
            m_hv[i]    = 0;
            m_since[i] = BIG;
        end
        m_err = '0;
        m_cnt = 0;
    endtask

    task automatic model_push(input logic r, input logic [CH-1:0] e, input logic c);
        exp_t x;
        int   nv;
        bit   d;
        x.st = '0; x.chg = '0; x.ro = '0; x.fe = '0; x.vi = '0; x.er = '0; x.cnt = '0;
        nv = 0;
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (e[i]) begin
                    if (m_hv[i]) begin
                        d         = (cur[i] != m_prev[i]);
                        x.st[i]   = !d;
                        x.chg[i]  = d;
                        x.ro[i]   = (m_prev[i][0] == 1'b0) && (cur[i][0] == 1'b1);
                        x.fe[i]   = (m_prev[i][0] == 1'b1) && (cur[i][0] == 1'b0);
                        if (d && MS > 0 && m_since[i] < MS) begin
                            x.vi[i] = 1'b1;
                            nv++;
                        end
                        m_since[i] = d ? 0 : ((m_since[i] >= BIG) ? BIG : m_since[i] + 1);
                    end else begin
                        m_since[i] = BIG;
                    end
                    m_prev[i] = cur[i];
                    m_hv[i]   = 1;
                end else begin
                    m_hv[i]    = 0;
                    m_since[i] = BIG;
                end
            end
            m_err = (c ? '0 : m_err) | x.vi;
            m_cnt = (c ? 0 : m_cnt) + nv;
            if (m_cnt > CMAX) m_cnt = CMAX;
        end
        x.er  = m_err;
        x.cnt = CW'(m_cnt);
        sbq.push_back(x);
    endtask

    // One clock of stimulus: drive just after the falling edge, predict the next rising edge.
    task automatic step(input logic r, input logic [CH-1:0] e, input logic c);
        @(negedge clk);
        #1;
        rst   = r;
        en_i  = e;
        clr_i = c;
        sig_i = {cur[3], cur[2], cur[1], cur[0]};
        if (r) begin
            #1;
            chk("async_rst_outputs",
                32'({steady_o, changed_o, rose_o, fell_o, viol_o, err_o, viol_cnt_o}), 32'd0);
        end
        model_push(r, e, c);
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk("steady",  32'(steady_o),   32'(x.st));
            chk("changed", 32'(changed_o),  32'(x.chg));
            chk("rose",    32'(rose_o),     32'(x.ro));
            chk("fell",    32'(fell_o),     32'(x.fe));
            chk("viol",    32'(viol_o),     32'(x.vi));
            chk("err",     32'(err_o),      32'(x.er));
            chk("cnt",     32'(viol_cnt_o), 32'(x.cnt));
        end
    end

    initial begin
        rst   = 1'b1;
        en_i  = '0;
        clr_i = 1'b0;
        sig_i = '0;
        for (int i = 0; i < CH; i++) cur[i] = '0;
        model_reset();

        step(1, 4'hF, 0);
        step(1, 4'hF, 0);
        repeat (5) step(0, 4'hF, 0);

        // Rising LSB on ch0, then hold.
        cur[0] = 8'h01;
        repeat (3) step(0, 4'hF, 0);

        // ch1: change, second change three cycles later (illegal), then four later (legal).
        cur[1] = 8'h10; step(0, 4'hF, 0);
        step(0, 4'hF, 0); step(0, 4'hF, 0);
        cur[1] = 8'h20; step(0, 4'hF, 0);
        repeat (3) step(0, 4'hF, 0);
        cur[1] = 8'h31; step(0, 4'hF, 0);
        step(0, 4'hF, 0);

        // Violations on ch2/ch3 coinciding with clear.
        cur[2] = 8'h01; cur[3] = 8'h81; step(0, 4'hF, 0);
        cur[2] = 8'h00; cur[3] = 8'h80; step(0, 4'hF, 1);
        step(0, 4'hF, 0);

        // Back-to-back toggles on all channels drive the counter into saturation.
        repeat (4) begin
            for (int i = 0; i < CH; i++) cur[i] ^= 8'h01;
            step(0, 4'hF, 0);
        end
        step(0, 4'hF, 1);

        // ch0 disabled for two cycles while toggling, then one priming cycle.
        repeat (4) step(0, 4'hF, 0);
        cur[0] ^= 8'h01; step(0, 4'hE, 0);
        cur[0] ^= 8'h01; step(0, 4'hE, 0);
        cur[0] ^= 8'h01; step(0, 4'hF, 0);
        cur[0] ^= 8'h01; step(0, 4'hF, 0);
        step(0, 4'hF, 0);

        // Reset in the middle of a burst of changes.
        for (int i = 0; i < CH; i++) cur[i] ^= 8'h03;
        step(0, 4'hF, 0);
        for (int i = 0; i < CH; i++) cur[i] ^= 8'h01;
        step(0, 4'hF, 0);
        step(1, 4'hF, 0);
        step(0, 4'hF, 0);
        step(0, 4'hF, 0);

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [CH-1:0] e;
            logic          c, r;
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 2) == 0) cur[i] = 8'($urandom);
            e = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
            c = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 199) == 0);
            step(r, e, c);
        end

        @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
